// File: rtl/iobuf_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iobuf_bus_ctrl
// Brief    : Arbitrating sequencer for a bidirectional IOBUF pad bus with
//            turnaround and read sample-wait enforcement.
// Revision : 1.0 - initial release
// ============================================================================
module iobuf_bus_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TURN    = 2,
  parameter int RD_WAIT = 1
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             WR_REQ,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_ACK,
  input  logic             RD_REQ,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VLD,
  output logic [WIDTH-1:0] PAD_I,
  output logic             PAD_T,
  input  logic [WIDTH-1:0] PAD_O,
  output logic             BUSY
);

  localparam int c_CNT_MAX = (TURN > RD_WAIT) ? TURN : RD_WAIT;
  localparam int c_CW      = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
  localparam logic [c_CW-1:0] c_TURN_LD  = c_CW'(TURN - 1);
  localparam logic [c_CW-1:0] c_RWAIT_LD = c_CW'(RD_WAIT - 1);
  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
  localparam logic [c_CW-1:0] c_ZERO     = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RWAIT = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [c_CW-1:0]   cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [WIDTH-1:0]  pad_i_q, pad_i_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic              pad_t_q;
  logic              busy_q;
  logic              w_ack;
  logic              w_grant_wr;
  logic              w_grant_rd;

  // last_q = 1 means the write side won the previous grant.
  assign w_grant_wr = WR_REQ & (~RD_REQ | ~last_q);
  assign w_grant_rd = RD_REQ & (~WR_REQ |  last_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    pad_i_d   = pad_i_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    w_ack     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_ack   = 1'b1;
          pad_i_d = WR_DATA;
          state_d = S_DRIVE;
          last_d  = 1'b1;
        end else if (w_grant_rd) begin
          state_d = S_RWAIT;
          cnt_d   = c_RWAIT_LD;
          last_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        // A pending read closes the burst after the word on the pad.
        w_ack = ~RD_REQ;
        if (WR_REQ && !RD_REQ) begin
          pad_i_d = WR_DATA;
        end else begin
          state_d = S_TURN;
          cnt_d   = c_TURN_LD;
        end
      end
      S_RWAIT: begin
        if (cnt_q == c_ZERO) begin
          rd_data_d = PAD_O;
          rd_vld_d  = 1'b1;
          state_d   = S_TURN;
          cnt_d     = c_TURN_LD;
        end else begin
          cnt_d = cnt_q - c_ONE;
        end
      end
      S_TURN: begin
        if (cnt_q == c_ZERO) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - c_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = c_ZERO;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= c_ZERO;
      last_q    <= 1'b0;
      pad_i_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      pad_t_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      pad_i_q   <= pad_i_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      pad_t_q   <= (state_d != S_DRIVE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // Ready is combinational, so it is forced low while reset is asserted.
  assign WR_ACK  = w_ack & CLR_N;
  assign RD_DATA = rd_data_q;
  assign RD_VLD  = rd_vld_q;
  assign PAD_I   = pad_i_q;
  assign PAD_T   = pad_t_q;
  assign BUSY    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_iobuf_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iobuf_bus_ctrl
// Brief    : Directed scoreboard bench for iobuf_bus_ctrl (WIDTH=8, TURN=2,
//            RD_WAIT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iobuf_bus_ctrl;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             CLR_N;
  logic             WR_REQ;
  logic [WIDTH-1:0] WR_DATA;
  logic             WR_ACK;
  logic             RD_REQ;
  logic [WIDTH-1:0] RD_DATA;
  logic             RD_VLD;
  logic [WIDTH-1:0] PAD_I;
  logic             PAD_T;
  logic [WIDTH-1:0] PAD_O;
  logic             BUSY;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_pad[$];
  logic [WIDTH-1:0] exp_rd[$];
  int since_vld = 100;
  int since_drv = 100;

  iobuf_bus_ctrl #(.WIDTH(WIDTH), .TURN(2), .RD_WAIT(1)) dut (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .WR_REQ  (WR_REQ),
    .WR_DATA (WR_DATA),
    .WR_ACK  (WR_ACK),
    .RD_REQ  (RD_REQ),
    .RD_DATA (RD_DATA),
    .RD_VLD  (RD_VLD),
    .PAD_I   (PAD_I),
    .PAD_T   (PAD_T),
    .PAD_O   (PAD_O),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the pad is driven or a read returns.
  always @(negedge CLK) begin
    if (CLR_N) begin
      if (RD_VLD) since_vld = 0; else since_vld++;
      if (!PAD_T) begin
        if (exp_pad.size() == 0) chk("pad_unexpected", {24'd0, PAD_I}, 32'hFFFF_FFFF);
        else chk("pad_word", {24'd0, PAD_I}, {24'd0, exp_pad.pop_front()});
        chk("rd_to_drive_gap", {31'd0, since_vld >= 3}, 32'd1);
        since_drv = 0;
      end else begin
        since_drv++;
      end
      if (RD_VLD) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", {24'd0, RD_DATA}, 32'hFFFF_FFFF);
        else chk("rd_data", {24'd0, RD_DATA}, {24'd0, exp_rd.pop_front()});
        chk("drive_to_sample_gap", {31'd0, since_drv >= 4}, 32'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR_N = 1'b1; WR_REQ = 1'b0; WR_DATA = '0; RD_REQ = 1'b0; PAD_O = '0;
    #1 CLR_N = 1'b0;
    WR_REQ = 1'b1;
    #1;
    chk("rst_pad_t",   {31'd0, PAD_T},  32'd1);
    chk("rst_pad_i",   {24'd0, PAD_I},  32'd0);
    chk("rst_rd_data", {24'd0, RD_DATA}, 32'd0);
    chk("rst_rd_vld",  {31'd0, RD_VLD}, 32'd0);
    chk("rst_busy",    {31'd0, BUSY},   32'd0);
    chk("rst_wr_ack",  {31'd0, WR_ACK}, 32'd0);
    WR_REQ = 1'b0;
    tick(); tick();
    CLR_N = 1'b1;
    tick();

    // Single write 0xA5
    WR_REQ = 1'b1; WR_DATA = 8'hA5; exp_pad.push_back(8'hA5);
    #1 chk("single_ack", {31'd0, WR_ACK}, 32'd1);
    tick();
    WR_REQ = 1'b0;
    chk("single_pad_t", {31'd0, PAD_T}, 32'd0);
    chk("single_pad_i", {24'd0, PAD_I}, 32'hA5);
    tick();
    chk("single_turn1_t", {31'd0, PAD_T}, 32'd1);
    chk("single_turn1_busy", {31'd0, BUSY}, 32'd1);
    tick();
    chk("single_turn2_busy", {31'd0, BUSY}, 32'd1);
    tick();
    chk("single_idle", {31'd0, BUSY}, 32'd0);

    // Burst 0x11, 0x22, 0x33
    for (int i = 1; i <= 3; i++) begin
      WR_REQ = 1'b1; WR_DATA = 8'(i * 8'h11); exp_pad.push_back(8'(i * 8'h11));
      #1 chk("burst_ack", {31'd0, WR_ACK}, 32'd1);
      tick();
      chk("burst_pad_t", {31'd0, PAD_T}, 32'd0);
      chk("burst_pad_i", {24'd0, PAD_I}, 32'(i * 8'h11));
    end
    WR_REQ = 1'b0;
    tick();
    chk("burst_end_t", {31'd0, PAD_T}, 32'd1);
    tick(); tick();
    chk("burst_idle", {31'd0, BUSY}, 32'd0);

    // Read 0x5C
    PAD_O = 8'h5C; RD_REQ = 1'b1; exp_rd.push_back(8'h5C);
    #1 chk("read_no_ack", {31'd0, WR_ACK}, 32'd0);
    tick();
    chk("read_rwait_t", {31'd0, PAD_T}, 32'd1);
    chk("read_rwait_busy", {31'd0, BUSY}, 32'd1);
    chk("read_rwait_vld", {31'd0, RD_VLD}, 32'd0);
    tick();
    chk("read_vld", {31'd0, RD_VLD}, 32'd1);
    chk("read_data", {24'd0, RD_DATA}, 32'h5C);
    chk("read_vld_t", {31'd0, PAD_T}, 32'd1);
    RD_REQ = 1'b0;
    tick();
    chk("read_vld_pulse", {31'd0, RD_VLD}, 32'd0);
    chk("read_turn_busy", {31'd0, BUSY}, 32'd1);
    tick();
    chk("read_idle", {31'd0, BUSY}, 32'd0);

    // Asynchronous reset in the middle of a burst
    WR_REQ = 1'b1; WR_DATA = 8'h40; exp_pad.push_back(8'h40);
    tick();
    WR_DATA = 8'h41;
    #6 CLR_N = 1'b0;
    #1;
    chk("async_pad_t", {31'd0, PAD_T}, 32'd1);
    chk("async_busy",  {31'd0, BUSY},  32'd0);
    chk("async_pad_i", {24'd0, PAD_I}, 32'd0);
    chk("async_ack",   {31'd0, WR_ACK}, 32'd0);
    tick();
    exp_pad.push_back(8'h41);
    CLR_N = 1'b1;
    #1 chk("post_rst_ack", {31'd0, WR_ACK}, 32'd1);
    tick();
    WR_REQ = 1'b0;
    chk("post_rst_pad_t", {31'd0, PAD_T}, 32'd0);
    chk("post_rst_pad_i", {24'd0, PAD_I}, 32'h41);
    tick(); tick(); tick();
    chk("post_rst_idle", {31'd0, BUSY}, 32'd0);

    // Contention from reset: write wins first (LAST=0), then read, then write
    #6 CLR_N = 1'b0;
    tick();
    WR_REQ = 1'b1; WR_DATA = 8'h77; RD_REQ = 1'b1; PAD_O = 8'h3C;
    exp_pad.push_back(8'h77); exp_rd.push_back(8'h3C);
    CLR_N = 1'b1;
    #1 chk("cont_ack_idle", {31'd0, WR_ACK}, 32'd1);
    tick();
    chk("cont_pad_i", {24'd0, PAD_I}, 32'h77);
    chk("cont_pad_t", {31'd0, PAD_T}, 32'd0);
    chk("cont_ack_drive", {31'd0, WR_ACK}, 32'd0);
    WR_DATA = 8'h78; exp_pad.push_back(8'h78);
    tick();
    chk("cont_turn1_t", {31'd0, PAD_T}, 32'd1);
    tick();
    chk("cont_turn2_busy", {31'd0, BUSY}, 32'd1);
    tick();
    chk("cont_idle", {31'd0, BUSY}, 32'd0);
    chk("cont_rd_wins", {31'd0, WR_ACK}, 32'd0);
    tick();
    chk("cont_rwait_t", {31'd0, PAD_T}, 32'd1);
    chk("cont_rwait_busy", {31'd0, BUSY}, 32'd1);
    tick();
    chk("cont_vld", {31'd0, RD_VLD}, 32'd1);
    RD_REQ = 1'b0;
    tick();
    chk("cont_s1_t", {31'd0, PAD_T}, 32'd1);
    chk("cont_s1_ack", {31'd0, WR_ACK}, 32'd0);
    tick();
    chk("cont_s2_t", {31'd0, PAD_T}, 32'd1);
    chk("cont_s2_ack", {31'd0, WR_ACK}, 32'd1);
    tick();
    chk("cont_s3_t", {31'd0, PAD_T}, 32'd0);
    chk("cont_s3_pad_i", {24'd0, PAD_I}, 32'h78);
    WR_REQ = 1'b0;
    tick(); tick(); tick();
    chk("cont_final_idle", {31'd0, BUSY}, 32'd0);

    tick();
    chk("pad_queue_empty", 32'(exp_pad.size()), 32'd0);
    chk("rd_queue_empty",  32'(exp_rd.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iobuf_bus_ctrl.md
# iobuf_bus_ctrl

Sequencing and arbitration controller for a WIDTH-bit bidirectional pad bus. The bus is built from IOBUF-style primitives: this block drives their I and T inputs and reads their O outputs. It shares the bus between a local write requester and a local read requester, and enforces turnaround and sample-wait cycles so the pad never drives while the far end may be driving. It sits between the core logic and the I/O buffer ring.

## Interface
- WIDTH, 8: pad bus width.
- TURN, 2: idle (high-Z) turnaround cycles after any transaction. Legal range is 1 or more.
- RD_WAIT, 1: cycles between read grant and PAD_O sample. Legal range is 1 or more.

- CLK  in  1  single clock; all state changes on the rising edge.
- CLR_N  in  1  asynchronous, active-low reset.
- WR_REQ  in  1  write word valid.
- WR_DATA  in  WIDTH  write word.
- WR_ACK  out  1  combinational ready; a word transfers at an edge where WR_REQ & WR_ACK.
- RD_REQ  in  1  read request (level).
- RD_DATA  out  WIDTH  last sampled pad value.
- RD_VLD  out  1  one-cycle pulse: RD_DATA updated.
- PAD_I  out  WIDTH  to IOBUF I.
- PAD_T  out  1  to IOBUF T; 1 = high-Z.
- PAD_O  in  WIDTH  from IOBUF O.
- BUSY  out  1  state != IDLE.

## Operation
- States:
  - IDLE: PAD_T=1.
  - DRIVE: PAD_T=0.
  - RWAIT: PAD_T=1, counts RD_WAIT.
  - TURN: PAD_T=1, counts TURN.
- Arbitration in IDLE, using the LAST register (0 = read granted last; reset value 0):
  - Only WR_REQ: grant write.
  - Only RD_REQ: grant read.
  - Both: grant the side opposite to LAST.
  - LAST updates on every grant.
- WR_ACK is 1 in these cases, and 0 otherwise and while CLR_N=0:
  - in IDLE when the write is granted;
  - in DRIVE when RD_REQ=0 (burst continuation).
- Write transfer edge: WR_DATA is registered into PAD_I and state becomes DRIVE.
- DRIVE exit:
  - Continues DRIVE while transfers keep occurring (back-to-back burst, no gaps).
  - With no transfer at the edge ending a DRIVE cycle, goes to TURN.
  - Any pending RD_REQ ends the burst after the current word.
- Read grant: goes to RWAIT. At the edge ending the last RWAIT cycle:
  - RD_DATA <= PAD_O and RD_VLD=1 for the next cycle;
  - state becomes TURN.
- TURN: held for exactly TURN cycles, then IDLE. Every DRIVE→RWAIT and RWAIT→DRIVE change passes through TURN and IDLE.
- RD_REQ still high when back in IDLE is a new read request. The requester drops RD_REQ in the RD_VLD cycle to avoid a repeat read.
- PAD_I holds its last value when not driving. It is don't-care while PAD_T=1 but must not glitch PAD_T.

## Timing
- All outputs except WR_ACK are registered.
- Reset (CLR_N=0) takes effect asynchronously, with no clock needed, from any state including mid-burst:
  - PAD_T=1 immediately;
  - PAD_I=0, RD_DATA=0, RD_VLD=0, BUSY=0, WR_ACK=0;
  - state IDLE, counters 0, LAST=0.
- Write transfer at edge E:
  - PAD_T=0 and PAD_I=word during cycle E..E+1.
  - With no further transfer: TURN during cycles E+1..E+1+TURN, IDLE from edge E+1+TURN.
- Read grant at edge E:
  - PAD_T=1 throughout.
  - Sample at edge E+RD_WAIT; RD_VLD high in cycle E+RD_WAIT..E+RD_WAIT+1.
  - IDLE from edge E+RD_WAIT+TURN.
- Minimum gaps:
  - Read sample to next PAD_T=0: TURN+1 edges.
  - Last drive edge to next read sample: TURN+1+RD_WAIT edges.
- Simultaneous WR_REQ/RD_REQ in IDLE: resolved in the same cycle by LAST; no lost requests.

## Test plan
(WIDTH=8, TURN=2, RD_WAIT=1)
- **Async reset:** CLR_N low mid-burst between clock edges → PAD_T=1 and BUSY=0 before the next edge; after release the first write appears on PAD_I.
- **Single write:** WR_DATA=0xA5 → PAD_T=0 for one cycle with PAD_I=0xA5, then 2 cycles PAD_T=1 with BUSY=1, then BUSY=0.
- **Burst:** 0x11, 0x22, 0x33 with RD_REQ=0 → WR_ACK=1 on three consecutive edges; PAD_T=0 for exactly 3 contiguous cycles with PAD_I=0x11, 0x22, 0x33.
- **Read:** PAD_O=0x5C, RD_REQ at IDLE edge E → RD_DATA=0x5C, RD_VLD pulse in cycle E+1; PAD_T never 0; IDLE at E+3.
- **Contention from reset:** WR_REQ=1 (0x77) and RD_REQ=1 together → write first:
  - 0x77 driven one cycle, WR_ACK=0 in DRIVE;
  - then TURN (2 cycles), IDLE, read granted, RD_VLD;
  - then TURN, and the next write is granted.
- **Read→write spacing:** read sample at edge S, WR_REQ held → first PAD_T=0 cycle no earlier than edge S+3; no cycle anywhere has PAD_T=0 inside a TURN/RWAIT window.
